priority_ser_n_v: RTL and testbench

- Parametrised, registered successor to the fixed 8→3 combinational priority encoder.
- Accepts an N-bit request vector under a valid/ready handshake.
- Emits the index of every set bit, one per cycle, highest index first, under an output valid/ready handshake. Flags the last index of each vector.
- Sits between interrupt/event collection logic and a single-index consumer, e.g. a dispatcher or mux select.

---
 rtl/priority_ser_n_v_pkg.sv | 24 ++
 rtl/priority_ser_n_v_enc.sv | 30 +++
 rtl/priority_ser_n_v.sv | 103 ++++++++++
 tb/tb_priority_ser_n_v.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/priority_ser_n_v_pkg.sv
// Shared definitions for the priority serializer family.
// Build option: PRIORITY_SER_LSB_FIRST_EN selects ascending (lowest index
// first) emission order; undefined keeps the legacy highest-index-first order.
package priority_pkg_v;

  localparam int N_DEFAULT = 8;

`ifdef PRIORITY_SER_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  // Local ceil(log2) so the index width does not depend on tool support of $clog2.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_ser_n_v_enc.sv
// Combinational parametrised find-first-set: N-bit vector to W-bit index plus
// any-valid. Direction follows LSB_FIRST (PRIORITY_SER_LSB_FIRST_EN); the
// default picks the highest set index, matching the fixed 4->2 / 8->3 encoders.
module priority_enc_n_v
  import priority_pkg_v::*;
#(
  parameter int  N = N_DEFAULT,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // Scan so that the winning bit is the last one written.
  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    if (LSB_FIRST) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (i_vec[k]) o_idx = W'(k);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (i_vec[k]) o_idx = W'(k);
      end
    end
  end

endmodule

// File: rtl/priority_ser_n_v.sv
// Registered priority serializer: accepts an N-bit request vector and emits
// the index of each set bit, one per cycle, flagging the last one.
// Build option: PRIORITY_SER_LSB_FIRST_EN emits ascending instead of descending.
// The IDLE/DRAIN state is implicit: IDLE when pend_q == 0, DRAIN otherwise.
module priority_ser_n_v
  import priority_pkg_v::*;
#(
  parameter int  N = N_DEFAULT,
  localparam int W = clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_req_vld,
  output logic         o_req_rdy,
  output logic [W-1:0] o_code,
  output logic         o_vld,
  output logic         o_last,
  input  logic         i_rdy
);

  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] code_q, code_d;
  logic         vld_q, vld_d;
  logic         last_q, last_d;

  logic [W-1:0] req_idx, pend_idx;
  logic         req_any, pend_any;
  logic [N-1:0] req_rest, pend_rest;
  logic         slot_free, accept;

  function automatic logic [N-1:0] clear_bit(input logic [N-1:0] v,
                                             input logic [W-1:0] idx);
    logic [N-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return v & ~m;
  endfunction

  priority_enc_n_v #(.N(N)) u_enc_req (
    .i_vec (i_req),
    .o_idx (req_idx),
    .o_any (req_any)
  );

  priority_enc_n_v #(.N(N)) u_enc_pend (
    .i_vec (pend_q),
    .o_idx (pend_idx),
    .o_any (pend_any)
  );

  assign req_rest  = clear_bit(i_req, req_idx);
  assign pend_rest = clear_bit(pend_q, pend_idx);
  assign slot_free = !vld_q || i_rdy;
  assign o_req_rdy = (pend_q == '0) && slot_free;
  assign accept    = i_req_vld && o_req_rdy;

  // Next-state: accept a new vector, drain the pending one, or go empty.
  // Accept and drain are exclusive because accepting requires pend_q == 0.
  always_comb begin
    pend_d = pend_q;
    code_d = code_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (accept) begin
      if (req_any) begin
        code_d = req_idx;
        pend_d = req_rest;
        vld_d  = 1'b1;
        last_d = (req_rest == '0);
      end else begin
        vld_d  = 1'b0;
      end
    end else if (pend_any && slot_free) begin
      code_d = pend_idx;
      pend_d = pend_rest;
      vld_d  = 1'b1;
      last_d = (pend_rest == '0);
    end else if (slot_free) begin
      vld_d  = 1'b0;
    end
  end

  // State registers; reset mid-drain discards any remaining indices.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= '0;
      code_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      code_q <= code_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign o_code = code_q;
  assign o_vld  = vld_q;
  assign o_last = last_q;

endmodule

// File: tb/tb_priority_ser_n_v.sv
// Bench for priority_ser_n_v (N = 8): cycle-table directed scenarios, a reset
// mid-drain sequence, and randomized traffic against an index-queue model.
module tb_priority_ser_n_v;

`ifdef PRIORITY_SER_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       req_vld;
  logic       req_rdy;
  logic [2:0] code;
  logic       vld;
  logic       last;
  logic       rdy;

  int n_vec;
  int n_err;

  priority_ser_n_v #(.N(8)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_req_vld (req_vld),
    .o_req_rdy (req_rdy),
    .o_code    (code),
    .o_vld     (vld),
    .o_last    (last),
    .i_rdy     (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs held for one cycle and the outputs expected in that cycle.
  typedef struct {
    logic [7:0] req;
    logic       rvld;
    logic       rdy;
    logic       evld;
    logic [2:0] ecode;
    logic       elast;
    logic       erdy;
  } row_t;

  row_t rows[$];

  // Index-queue reference model.
  int m_pend[$];
  bit m_vld;
  bit m_last;
  int m_code;

  function automatic int sel(input int msb_first, input int lsb_first);
    return LSB ? lsb_first : msb_first;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] r, input logic rv, input logic rd,
                     input logic ev, input int ec, input logic el, input logic er);
    row_t x;
    x.req = r; x.rvld = rv; x.rdy = rd;
    x.evld = ev; x.ecode = 3'(ec); x.elast = el; x.erdy = er;
    rows.push_back(x);
  endtask

  task automatic model_reset();
    m_pend.delete();
    m_vld  = 0;
    m_last = 0;
    m_code = 0;
  endtask

  function automatic bit model_req_rdy(input bit r);
    return (m_pend.size() == 0) && (!m_vld || r);
  endfunction

  // Advance the model across one clock edge with the given inputs.
  task automatic model_step(input logic [7:0] r, input bit rv, input bit rd);
    bit slot;
    bit acc;
    slot = !m_vld || rd;
    acc  = rv && model_req_rdy(rd);
    if (acc) begin
      for (int k = 0; k < 8; k++) begin
        int b;
        b = LSB ? k : 7 - k;
        if (r[b]) m_pend.push_back(b);
      end
      if (m_pend.size() > 0) begin
        m_code = m_pend.pop_front();
        m_vld  = 1;
        m_last = (m_pend.size() == 0);
      end else begin
        m_vld = 0;
      end
    end else if (m_pend.size() > 0 && slot) begin
      m_code = m_pend.pop_front();
      m_vld  = 1;
      m_last = (m_pend.size() == 0);
    end else if (slot) begin
      m_vld = 0;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req = '0; req_vld = 1'b0; rdy = 1'b0;

    // Idle and basic vector with back-to-back single-bit follow-on
    add(8'h00, 0, 1, 0, 0, 0, 1);
    add(8'h94, 1, 1, 0, 0, 0, 1);
    add(8'h00, 0, 1, 1, sel(7, 2), 0, 0);
    add(8'h00, 0, 1, 1, 4, 0, 0);
    add(8'h01, 1, 1, 1, sel(2, 7), 1, 1);
    add(8'h00, 0, 1, 1, 0, 1, 1);
    add(8'h00, 0, 1, 0, 0, 0, 1);
    // Backpressure for three cycles on the first index
    add(8'h06, 1, 1, 0, 0, 0, 1);
    add(8'h00, 0, 0, 1, sel(2, 1), 0, 0);
    add(8'h00, 0, 0, 1, sel(2, 1), 0, 0);
    add(8'h00, 0, 0, 1, sel(2, 1), 0, 0);
    add(8'h00, 0, 1, 1, sel(2, 1), 0, 0);
    add(8'h00, 0, 1, 1, sel(1, 2), 1, 1);
    add(8'h00, 0, 1, 0, 0, 0, 1);
    // Empty vector is consumed and dropped
    add(8'h00, 1, 1, 0, 0, 0, 1);
    add(8'h00, 0, 1, 0, 0, 0, 1);
    // Input changes while draining are ignored
    add(8'h81, 1, 1, 0, 0, 0, 1);
    add(8'h10, 1, 1, 1, sel(7, 0), 0, 0);
    add(8'h10, 1, 1, 1, sel(0, 7), 1, 1);
    add(8'h00, 0, 1, 1, 4, 1, 1);
    add(8'h00, 0, 1, 0, 0, 0, 1);
    // Full vector
    add(8'hFF, 1, 1, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++)
      add(8'h00, 0, 1, 1, LSB ? k : 7 - k, k == 7, k == 7);
    add(8'h00, 0, 1, 0, 0, 0, 1);

    // Reset state
    #12;
    chk("reset_vld", vld, 0);
    chk("reset_code", code, 0);
    chk("reset_last", last, 0);
    chk("reset_req_rdy", req_rdy, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (rows[i]) begin
      @(negedge clk);
      req = rows[i].req; req_vld = rows[i].rvld; rdy = rows[i].rdy;
      #1;
      chk($sformatf("row%0d_vld", i), vld, rows[i].evld);
      if (rows[i].evld) begin
        chk($sformatf("row%0d_code", i), code, rows[i].ecode);
        chk($sformatf("row%0d_last", i), last, rows[i].elast);
      end
      chk($sformatf("row%0d_req_rdy", i), req_rdy, rows[i].erdy);
    end

    // Reset mid-drain: accept 0xFF, consume three indices, then reset
    @(negedge clk);
    req = 8'hFF; req_vld = 1'b1; rdy = 1'b1;
    @(negedge clk);
    req = 8'h00; req_vld = 1'b0;
    #1 chk("mid_first", code, sel(7, 0));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 chk("mid_fourth", code, sel(4, 3));
    chk("mid_vld_before", vld, 1);
    rst_n = 1'b0;
    #1 chk("mid_rst_vld", vld, 0);
    chk("mid_rst_req_rdy", req_rdy, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 chk("post_rst_vld", vld, 0);
      chk("post_rst_req_rdy", req_rdy, 1);
    end

    // Randomized traffic against the model
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 8'h00;
      else req = 8'($urandom & $urandom);
      req_vld = 1'($urandom_range(0, 1));
      rdy     = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_vld", vld, m_vld);
      if (m_vld) begin
        chk("rnd_code", code, m_code);
        chk("rnd_last", last, m_last);
      end
      chk("rnd_req_rdy", req_rdy, model_req_rdy(rdy));
      @(posedge clk);
      model_step(req, req_vld, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
